load_data_align_unit: RTL
=========================

// Module: load_data_align_unit
// PURPOSE
// Parametrised load-result datapath for the D$DATA/WB stages. Per load port it selects
// store-forwarded, MSHR or D$ line data, byte-aligns and sign/zero-extends it.
// New vs. the previous generation: configurable port count and data width (32/64),
// registered response, and a split-access FSM that merges two line reads for cache-line-crossing loads.
// PARAMETERS
// LOAD_PORTS  2   number of independent load lanes
// DATA_WIDTH  32  result width; 32 or 64 (64 enables dword loads)
// LINE_BYTES  16  D$/MSHR line size in bytes (power of 2)
// FWD_BYTES   8   LSQ forwarding block size in bytes (power of 2, <= LINE_BYTES)
// ADDR_WIDTH  32  physical address width
// PORTS  (arrays are [LOAD_PORTS])
// clk           in   1               clock
// rst           in   1               asynchronous, active-high reset
// stall         in   1               backend stall; freezes all state
// flush         in   [P]             kill in-flight op of lane p
// req_valid     in   [P]             load issued this cycle (D$TAG stage)
// req_addr      in   [P][ADDR_WIDTH] load byte address
// req_size      in   [P][2]          0 byte, 1 half, 2 word, 3 dword
// req_signed    in   [P]             1 = sign-extend
// fwd_hit       in   [P]             store-load forward hit (valid with req)
// fwd_data      in   [P][FWD_BYTES*8]  forwarded block
// mshr_hit      in   [P]             MSHR hit for the current beat (valid with req / second_req)
// mshr_data     in   [P][LINE_BYTES*8] MSHR line
// dc_data       in   [P][LINE_BYTES*8] D$ line, valid one cycle after req or second_req
// req_ready     out  [P]             lane can accept req this cycle
// second_req    out  [P]             request next line (split beat 2)
// second_addr   out  [P][ADDR_WIDTH] line-aligned address of the second line
// resp_valid    out  [P]             result valid (registered)
// resp_data     out  [P][DATA_WIDTH] aligned, extended result
// resp_split    out  [P]             result came from a merged split access
// BEHAVIOUR
// Reset (async): all outputs 0; req_ready = 1; FSMs to IDLE; capture registers 0.
// stall=1: no capture, no state change, outputs hold (resp_valid holds its value).
// Size: bytes = 1<<req_size; size 3 with DATA_WIDTH=32 is treated as word.
// Split: offset = addr mod LINE_BYTES; split = offset + bytes > LINE_BYTES.
// Lane FSM: IDLE -> BEAT1 -> (split ? BEAT2 -> IDLE : IDLE).
// IDLE: req_valid & req_ready -> latch addr/size/signed/fwd/mshr into stage reg, enter BEAT1.
// BEAT1 (cycle N+1): select fwd_data (block, shift by addr mod FWD_BYTES) > mshr_data > dc_data.
//   Non-split: shift, extend, register -> resp_valid=1 at N+2; IDLE, new req may be accepted in N+1.
//   Split: latch low line; second_req=1, second_addr = line(addr)+LINE_BYTES; req_ready=0; enter BEAT2.
// BEAT2 (N+2): high line = mshr_hit ? mshr_data : dc_data; merge {high,low} >> offset*8, extend;
//   resp_valid=1, resp_split=1 at N+3; IDLE; req_ready=1 from N+3 (low in N+1, N+2).
// fwd_hit is ignored on split accesses (LSQ never forwards line-crossing loads).
// resp_valid is a 1-cycle pulse per completed load unless stall holds it.
// flush[p]: lane p -> IDLE next edge, pending result dropped; second_req deasserted; a req
//   accepted in the same cycle as flush is also dropped. Flush beats stall.
// Lanes are fully independent; same-cycle split on several lanes is legal.
// Address wrap: second_addr wraps modulo 2^ADDR_WIDTH.
// STRUCTURE
// Package LoadAlignTypes: MemSize enum, LINE/FWD byte-width constants, lane state enum,
//   functions ShiftLine(), ShiftFwd(), ExtendLoad(data,size,signed,DATA_WIDTH).
// Sub-module load_align_lane (one FSM + datapath); top generates LOAD_PORTS instances.
// TESTING
// 1 word at 0x1004, dc_data bytes 4..7 = 0x8899AABB, unsigned -> resp_data 0x8899AABB at N+2, split=0.
// 2 signed byte at 0x1003, byte = 0x80, fwd_hit=1 over dc -> resp 0xFFFFFF80; dc value ignored.
// 3 word at 0x100E (LINE 16): low bytes 0x22,0x11; high-line bytes 0x44,0x33 -> second_addr 0x1010,
//   req_ready=0 for N+1..N+2, resp 0x33441122 at N+3, resp_split=1.
// 4 split with mshr_hit=1 on beat 2 -> high half taken from mshr_data, not dc_data.
// 5 stall=1 for 3 cycles in BEAT2 -> second_req/state held, resp exactly once after release.
// 6 flush in BEAT2, then rst asserted async mid-op -> no resp_valid; outputs 0, req_ready=1 immediately.

Source files
------------

// File: rtl/load_data_align_unit_pkg.sv
// Shared types and alignment/extension helpers for the load result datapath.
// Helpers work on worst-case widths; lanes zero-extend their narrower lines into them.
package LoadAlignTypes;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'd0,
    SIZE_HALF  = 2'd1,
    SIZE_WORD  = 2'd2,
    SIZE_DWORD = 2'd3
  } MemSize;

  typedef enum logic [1:0] {
    LANE_IDLE  = 2'd0,
    LANE_BEAT1 = 2'd1,
    LANE_BEAT2 = 2'd2
  } LaneState;

  localparam int MAX_LINE_BYTES = 64;
  localparam int MAX_LINE_BITS  = MAX_LINE_BYTES * 8;
  localparam int MAX_MERGE_BITS = 2 * MAX_LINE_BITS;

  // A 32-bit datapath has no dword loads; they degrade to word accesses.
  function automatic MemSize EffSize(input MemSize size, input int dataWidth);
    return (size == SIZE_DWORD && dataWidth == 32) ? SIZE_WORD : size;
  endfunction

  function automatic logic [63:0] ShiftLine(input logic [MAX_MERGE_BITS-1:0] merged,
                                            input logic [7:0] byteOff);
    return 64'(merged >> {byteOff, 3'b000});
  endfunction

  function automatic logic [63:0] ShiftFwd(input logic [MAX_LINE_BITS-1:0] blk,
                                           input logic [7:0] byteOff);
    return 64'(blk >> {byteOff, 3'b000});
  endfunction

  function automatic logic [63:0] ExtendLoad(input logic [63:0] data, input MemSize size,
                                             input logic isSigned, input int dataWidth);
    logic [63:0] ext;
    case (EffSize(size, dataWidth))
      SIZE_BYTE: ext = {{56{isSigned & data[7]}}, data[7:0]};
      SIZE_HALF: ext = {{48{isSigned & data[15]}}, data[15:0]};
      SIZE_WORD: ext = {{32{isSigned & data[31]}}, data[31:0]};
      default:   ext = data;
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/load_data_align_unit_lane.sv
// One load lane: stage register, IDLE/BEAT1/BEAT2 FSM and the align/extend datapath.
// A line-crossing load keeps the low line from beat 1 and merges it with beat 2's line.
module load_align_lane
  import LoadAlignTypes::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_BYTES = 16,
  parameter int FWD_BYTES  = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    reqValid,
  input  logic [ADDR_WIDTH-1:0]   reqAddr,
  input  logic [1:0]              reqSize,
  input  logic                    reqSigned,
  input  logic                    fwdHit,
  input  logic [FWD_BYTES*8-1:0]  fwdData,
  input  logic                    mshrHit,
  input  logic [LINE_BYTES*8-1:0] mshrData,
  input  logic [LINE_BYTES*8-1:0] dcData,
  output logic                    reqReady,
  output logic                    secondReq,
  output logic [ADDR_WIDTH-1:0]   secondAddr,
  output logic                    respValid,
  output logic [DATA_WIDTH-1:0]   respData,
  output logic                    respSplit
);

  localparam int LINE_BITS     = LINE_BYTES * 8;
  localparam int FWD_BITS      = FWD_BYTES * 8;
  localparam int LINE_OFF_BITS = $clog2(LINE_BYTES);
  localparam int FWD_OFF_BITS  = $clog2(FWD_BYTES);

  LaneState              stateReg, stateNext;
  logic [ADDR_WIDTH-1:0] addrReg;
  MemSize                sizeReg;
  logic                  signedReg, fwdHitReg, mshrHitReg;
  logic [FWD_BITS-1:0]   fwdDataReg;
  logic [LINE_BITS-1:0]  mshrDataReg, lowLineReg;
  logic                  respValidReg, respSplitReg;
  logic [DATA_WIDTH-1:0] respDataReg;

  logic [7:0]                lineOff, fwdOff, accBytes;
  logic                      splitAcc, readyInt, accept, complete, captureLow;
  logic [LINE_BITS-1:0]      srcLine;
  logic [MAX_MERGE_BITS-1:0] merged;
  logic [MAX_LINE_BITS-1:0]  fwdWide;
  logic [63:0]               aligned;
  logic [DATA_WIDTH-1:0]     respDataNext;
  logic [ADDR_WIDTH-1:0]     lineBase;

  always_comb begin
    lineOff  = 8'(addrReg[LINE_OFF_BITS-1:0]);
    fwdOff   = 8'(addrReg[FWD_OFF_BITS-1:0]);
    accBytes = 8'd1 << EffSize(sizeReg, DATA_WIDTH);
    splitAcc = (lineOff + accBytes) > 8'(LINE_BYTES);
  end

  // A non-split op in BEAT1 retires this cycle, so a new load can overlap it.
  always_comb begin
    stateNext  = stateReg;
    readyInt   = 1'b0;
    complete   = 1'b0;
    captureLow = 1'b0;
    case (stateReg)
      LANE_IDLE:  readyInt = 1'b1;
      LANE_BEAT1: readyInt = !splitAcc;
      default:    readyInt = 1'b0;
    endcase
    accept = reqValid && readyInt;
    case (stateReg)
      LANE_IDLE: if (accept) stateNext = LANE_BEAT1;
      LANE_BEAT1: begin
        if (splitAcc) begin
          captureLow = 1'b1;
          stateNext  = LANE_BEAT2;
        end else begin
          complete  = 1'b1;
          stateNext = accept ? LANE_BEAT1 : LANE_IDLE;
        end
      end
      LANE_BEAT2: begin
        complete  = 1'b1;
        stateNext = LANE_IDLE;
      end
      default: stateNext = LANE_IDLE;
    endcase
  end

  // The MSHR stage slot holds the beat-1 line, then is reloaded for beat 2.
  always_comb begin
    srcLine = mshrHitReg ? mshrDataReg : dcData;
    merged  = '0;
    if (stateReg == LANE_BEAT2) merged[2*LINE_BITS-1:0] = {srcLine, lowLineReg};
    else                        merged[LINE_BITS-1:0]   = srcLine;
    fwdWide = '0;
    fwdWide[FWD_BITS-1:0] = fwdDataReg;
    if (stateReg == LANE_BEAT1 && fwdHitReg && !splitAcc) aligned = ShiftFwd(fwdWide, fwdOff);
    else                                                  aligned = ShiftLine(merged, lineOff);
    respDataNext = DATA_WIDTH'(ExtendLoad(aligned, sizeReg, signedReg, DATA_WIDTH));
    lineBase     = addrReg & ~ADDR_WIDTH'(LINE_BYTES - 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg     <= LANE_IDLE;
      addrReg      <= '0;
      sizeReg      <= SIZE_BYTE;
      signedReg    <= 1'b0;
      fwdHitReg    <= 1'b0;
      fwdDataReg   <= '0;
      mshrHitReg   <= 1'b0;
      mshrDataReg  <= '0;
      lowLineReg   <= '0;
      respValidReg <= 1'b0;
      respSplitReg <= 1'b0;
      respDataReg  <= '0;
    end else if (flush) begin
      stateReg     <= LANE_IDLE;
      respValidReg <= 1'b0;
      respSplitReg <= 1'b0;
    end else if (!stall) begin
      stateReg     <= stateNext;
      respValidReg <= complete;
      respSplitReg <= complete && (stateReg == LANE_BEAT2);
      if (complete) respDataReg <= respDataNext;
      if (accept) begin
        addrReg     <= reqAddr;
        sizeReg     <= MemSize'(reqSize);
        signedReg   <= reqSigned;
        fwdHitReg   <= fwdHit;
        fwdDataReg  <= fwdData;
        mshrHitReg  <= mshrHit;
        mshrDataReg <= mshrData;
      end else if (captureLow) begin
        lowLineReg  <= srcLine;
        mshrHitReg  <= mshrHit;
        mshrDataReg <= mshrData;
      end
    end
  end

  assign reqReady   = readyInt;
  assign secondReq  = captureLow && !flush;
  assign secondAddr = secondReq ? lineBase + ADDR_WIDTH'(LINE_BYTES) : '0;
  assign respValid  = respValidReg;
  assign respData   = respDataReg;
  assign respSplit  = respSplitReg;

endmodule

// File: rtl/load_data_align_unit.sv
// Load result datapath for the D$DATA/WB stages: LOAD_PORTS independent align lanes.
module load_data_align_unit
  import LoadAlignTypes::*;
#(
  parameter int LOAD_PORTS = 2,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_BYTES = 16,
  parameter int FWD_BYTES  = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    stall,
  input  logic [LOAD_PORTS-1:0]                   flush,
  input  logic [LOAD_PORTS-1:0]                   req_valid,
  input  logic [LOAD_PORTS-1:0][ADDR_WIDTH-1:0]   req_addr,
  input  logic [LOAD_PORTS-1:0][1:0]              req_size,
  input  logic [LOAD_PORTS-1:0]                   req_signed,
  input  logic [LOAD_PORTS-1:0]                   fwd_hit,
  input  logic [LOAD_PORTS-1:0][FWD_BYTES*8-1:0]  fwd_data,
  input  logic [LOAD_PORTS-1:0]                   mshr_hit,
  input  logic [LOAD_PORTS-1:0][LINE_BYTES*8-1:0] mshr_data,
  input  logic [LOAD_PORTS-1:0][LINE_BYTES*8-1:0] dc_data,
  output logic [LOAD_PORTS-1:0]                   req_ready,
  output logic [LOAD_PORTS-1:0]                   second_req,
  output logic [LOAD_PORTS-1:0][ADDR_WIDTH-1:0]   second_addr,
  output logic [LOAD_PORTS-1:0]                   resp_valid,
  output logic [LOAD_PORTS-1:0][DATA_WIDTH-1:0]   resp_data,
  output logic [LOAD_PORTS-1:0]                   resp_split
);

  genvar gi;
  generate
    for (gi = 0; gi < LOAD_PORTS; gi++) begin : gLane
      load_align_lane #(
        .DATA_WIDTH(DATA_WIDTH),
        .LINE_BYTES(LINE_BYTES),
        .FWD_BYTES (FWD_BYTES),
        .ADDR_WIDTH(ADDR_WIDTH)
      ) uLane (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush[gi]),
        .reqValid  (req_valid[gi]),
        .reqAddr   (req_addr[gi]),
        .reqSize   (req_size[gi]),
        .reqSigned (req_signed[gi]),
        .fwdHit    (fwd_hit[gi]),
        .fwdData   (fwd_data[gi]),
        .mshrHit   (mshr_hit[gi]),
        .mshrData  (mshr_data[gi]),
        .dcData    (dc_data[gi]),
        .reqReady  (req_ready[gi]),
        .secondReq (second_req[gi]),
        .secondAddr(second_addr[gi]),
        .respValid (resp_valid[gi]),
        .respData  (resp_data[gi]),
        .respSplit (resp_split[gi])
      );
    end
  endgenerate

endmodule
